hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 45 ++++
 rtl/hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_hazard_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Purpose: bundles the hazard controller's pipeline-facing signals (hazard sources in, enables/flushes out).
// Latency: none, signal container only.
// Backpressure: none; the enables carried here are the pipeline's stall mechanism.
//
// Signals:
//   ID_Rs, ID_Rt      source registers of the instruction in ID
//   EX_MemRead, EX_Rd load-in-EX flag and its destination register
//   EX_BranchTaken    branch/jump resolved taken in EX
//   ME_MemReq, dm_ack data-memory access in ME and its completion strobe
//   *_En, *_Flush     pipeline register load enables and bubble inserts
//   mem_err           sticky data-memory timeout flag
//   stall_cnt         saturating count of cycles with PC_En low
interface hazard_ctrl_if;
    logic [4:0]  ID_Rs;
    logic [4:0]  ID_Rt;
    logic        EX_MemRead;
    logic [4:0]  EX_Rd;
    logic        EX_BranchTaken;
    logic        ME_MemReq;
    logic        dm_ack;

    logic        PC_En;
    logic        IFID_En;
    logic        IDEX_En;
    logic        EXME_En;
    logic        MEWB_En;
    logic        IFID_Flush;
    logic        IDEX_Flush;
    logic        mem_err;
    logic [15:0] stall_cnt;

    // slave: the hazard controller itself
    modport slave (
        input  ID_Rs, ID_Rt, EX_MemRead, EX_Rd, EX_BranchTaken, ME_MemReq, dm_ack,
        output PC_En, IFID_En, IDEX_En, EXME_En, MEWB_En, IFID_Flush, IDEX_Flush,
               mem_err, stall_cnt
    );

    // master: the pipeline datapath that supplies hazard sources and obeys the enables
    modport master (
        output ID_Rs, ID_Rt, EX_MemRead, EX_Rd, EX_BranchTaken, ME_MemReq, dm_ack,
        input  PC_En, IFID_En, IDEX_En, EXME_En, MEWB_En, IFID_Flush, IDEX_Flush,
               mem_err, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Purpose: pipeline hazard controller -- memory freeze, branch flush, load-use stall, memory timeout.
// Latency: enables/flushes are combinational from state and inputs; mem_err/stall_cnt register at the next edge.
// Backpressure: a pending data-memory access freezes every pipeline stage until dm_ack or timeout.
//
// Ports:
//   clk  pipeline clock
//   rst  synchronous active-high reset
//   hz   hazard_ctrl_if.slave (hazard sources in; enables, flushes, mem_err, stall_cnt out)
module hazard_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MWAIT = 2'd1,
        ERR   = 2'd2
    } state_t;

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [15:0] stall_cnt_q;
    logic        mem_err_q;

    logic        freeze;
    logic        load_use;

    logic        pc_en;
    logic        ifid_en;
    logic        idex_en;
    logic        exme_en;
    logic        mewb_en;
    logic        ifid_flush;
    logic        idex_flush;

    // Hazard detection. Register 0 is hardwired zero, so a load targeting it
    // can never produce a value a later instruction depends on.
    always_comb begin
        freeze   = hz.ME_MemReq && !hz.dm_ack;
        load_use = hz.EX_MemRead && (hz.EX_Rd != 5'd0) &&
                   ((hz.EX_Rd == hz.ID_Rs) || (hz.EX_Rd == hz.ID_Rt));
    end

    // Enable/flush decode, in priority order: reset, error, freeze, branch, load-use.
    // MWAIT needs no special case here: once the freeze condition drops, it
    // decodes exactly like RUN, which covers the ack cycle.
    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exme_en    = 1'b1;
        mewb_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;

        if (rst || (state == ERR) || freeze) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_en = 1'b0;
            exme_en = 1'b0;
            mewb_en = 1'b0;
        end else if (hz.EX_BranchTaken) begin
            // The taken branch squashes both younger instructions; the
            // load-use stall is moot because the dependent one is discarded.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF/ID, push a bubble into ID/EX. The bubble carries
            // EX_MemRead=0, so the stall cannot repeat for the same hazard.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // State, wait counter and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= 8'd0;
            mem_err_q <= 1'b0;
        end else begin
            case (state)
                RUN, MWAIT: begin
                    if (freeze) begin
                        // wait_cnt holds the number of freeze cycles already
                        // completed, so this fires on the (TIMEOUT+1)-th one.
                        if (wait_cnt == TIMEOUT_C) begin
                            state     <= ERR;
                            mem_err_q <= 1'b1;
                        end else begin
                            state <= MWAIT;
                        end
                        if (wait_cnt != 8'hFF) begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end else begin
                        state    <= RUN;
                        wait_cnt <= 8'd0;
                    end
                end
                ERR: begin
                    // Sticky until reset; inputs are ignored.
                    state     <= ERR;
                    mem_err_q <= 1'b1;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= 8'd0;
                end
            endcase
        end
    end

    // Stall statistics: every cycle the PC is held, including error cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
        end else if (!pc_en && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign hz.PC_En      = pc_en;
    assign hz.IFID_En    = ifid_en;
    assign hz.IDEX_En    = idex_en;
    assign hz.EXME_En    = exme_en;
    assign hz.MEWB_En    = mewb_en;
    assign hz.IFID_Flush = ifid_flush;
    assign hz.IDEX_Flush = idex_flush;
    assign hz.mem_err    = mem_err_q;
    assign hz.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose: self-checking bench for hazard_ctrl with a behavioural reference model and directed literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_hazard_ctrl;

    localparam int TMO = 255;

    logic clk;
    logic rst;

    hazard_ctrl_if hif ();

    hazard_ctrl #(.TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // ---------------- reference model ----------------
    // m_err: pipeline dead until reset; m_wait: consecutive frozen cycles so far;
    // m_stall: cycles with the PC held, clipped at 65535.
    bit       m_err = 1'b0;
    int       m_wait = 0;
    int       m_stall = 0;
    bit       frz;
    bit       hazard;
    bit [6:0] exp_v;
    bit [6:0] act_v;

    // Output vector order: {PC, IFID, IDEX, EXME, MEWB, IFID_Flush, IDEX_Flush}
    always @(negedge clk) begin
        frz    = hif.ME_MemReq && !hif.dm_ack;
        hazard = hif.EX_MemRead && (hif.EX_Rd != 0) &&
                 (hif.EX_Rd == hif.ID_Rs || hif.EX_Rd == hif.ID_Rt);
        if (rst || m_err || frz)       exp_v = 7'b00000_00;
        else if (hif.EX_BranchTaken)   exp_v = 7'b11111_11;
        else if (hazard)               exp_v = 7'b00111_01;
        else                           exp_v = 7'b11111_00;

        act_v = {hif.PC_En, hif.IFID_En, hif.IDEX_En, hif.EXME_En, hif.MEWB_En,
                 hif.IFID_Flush, hif.IDEX_Flush};

        if (chk_en) begin
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL model_outs t=%0t: got %b expected %b", $time, act_v, exp_v);
            end
            n_cmp++;
            if (hif.mem_err !== m_err) begin
                n_bad++;
                $display("FAIL model_mem_err t=%0t: got %b expected %b", $time, hif.mem_err, m_err);
            end
            n_cmp++;
            if (hif.stall_cnt !== 16'(m_stall)) begin
                n_bad++;
                $display("FAIL model_stall_cnt t=%0t: got %0d expected %0d", $time, hif.stall_cnt, m_stall);
            end
        end

        // Advance to what the coming rising edge must produce.
        if (rst) begin
            m_err   = 1'b0;
            m_wait  = 0;
            m_stall = 0;
        end else begin
            if (exp_v[6] == 1'b0 && m_stall < 65535) m_stall = m_stall + 1;
            if (!m_err) begin
                if (frz) begin
                    if (m_wait >= TMO) m_err = 1'b1;
                    m_wait = m_wait + 1;
                end else begin
                    m_wait = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                         input logic [4:0] rd, input logic br, input logic mq, input logic ack);
        hif.ID_Rs          = rs;
        hif.ID_Rt          = rt;
        hif.EX_MemRead     = mr;
        hif.EX_Rd          = rd;
        hif.EX_BranchTaken = br;
        hif.ME_MemReq      = mq;
        hif.dm_ack         = ack;
    endtask

    task automatic drive_rand();
        hif.ID_Rs          = 5'($urandom_range(0, 7));
        hif.ID_Rt          = 5'($urandom_range(0, 7));
        hif.EX_MemRead     = 1'($urandom_range(0, 1));
        hif.EX_Rd          = 5'($urandom_range(0, 7));
        hif.EX_BranchTaken = ($urandom_range(0, 4) == 0);
        hif.ME_MemReq      = 1'($urandom_range(0, 1));
        hif.dm_ack         = ($urandom_range(0, 9) < 7);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {hif.PC_En, hif.IFID_En, hif.IDEX_En, hif.EXME_En, hif.MEWB_En,
                hif.IFID_Flush, hif.IDEX_Flush};
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk_en = 1'b1;
        #3 lit("rst_outs_zero", 16'(outs()), 16'h0);
        tick();

        // Idle after reset
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #3;
        lit("reset_stall_cnt", hif.stall_cnt, 16'd0);
        lit("reset_mem_err", 16'(hif.mem_err), 16'd0);
        lit("idle_outs", 16'(outs()), 16'h7C);
        tick();

        // Load-use on Rt: one-cycle stall with a bubble into ID/EX
        drive(0, 5, 1, 5, 0, 0, 0);
        #3 lit("loaduse_outs", 16'(outs()), 16'h1D);
        tick();
        drive(0, 5, 0, 5, 0, 0, 0);   // bubble: EX_MemRead now clear
        #3;
        lit("loaduse_released", 16'(outs()), 16'h7C);
        lit("loaduse_stall_cnt", hif.stall_cnt, 16'd1);
        tick();

        // Branch wins over the same hazard
        drive(0, 5, 1, 5, 1, 0, 0);
        #3 lit("branch_over_loaduse", 16'(outs()), 16'h7F);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #3 lit("branch_stall_unchanged", hif.stall_cnt, 16'd1);
        tick();

        // Memory wait: three frozen cycles, then ack
        for (int i = 0; i < 3; i++) begin
            drive(0, 5, 1, 5, 0, 1, 0);
            #3 lit("mwait_frozen", 16'(outs()), 16'h0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 1, 1);
        #3 lit("mwait_ack_outs", 16'(outs()), 16'h7C);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #3 lit("mwait_stall_cnt", hif.stall_cnt, 16'd4);
        tick();

        // Load into r0 never stalls
        drive(0, 0, 1, 0, 0, 0, 0);
        #3;
        lit("r0_no_stall", 16'(hif.PC_En), 16'd1);
        lit("r0_no_bubble", 16'(hif.IDEX_Flush), 16'd0);
        tick();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            drive_rand();
            tick();
        end

        // Timeout: 300 frozen cycles, counted from 0
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0);
            #3;
            if (i == 255) lit("tmo_not_yet", 16'(hif.mem_err), 16'd0);
            if (i == 256) lit("tmo_mem_err", 16'(hif.mem_err), 16'd1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 1, 1);
        #3 lit("err_ignores_ack", 16'(outs()), 16'h0);
        tick();

        // Long error residency drives stall_cnt into saturation
        for (int i = 0; i < 65600; i++) begin
            drive_rand();
            tick();
        end
        #3;
        lit("stall_saturated", hif.stall_cnt, 16'hFFFF);
        lit("err_sticky", 16'(hif.mem_err), 16'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        #3 lit("stall_holds", hif.stall_cnt, 16'hFFFF);

        // Reset clears the error
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #3;
        lit("rst_clears_err", 16'(hif.mem_err), 16'd0);
        lit("rst_clears_stall", hif.stall_cnt, 16'd0);
        tick();

        // Reset in the middle of a memory wait
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0);
            tick();
        end
        rst = 1'b1;
        #3 lit("rst_mwait_outs", 16'(outs()), 16'h0);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #3;
        lit("post_rst_outs", 16'(outs()), 16'h7C);
        lit("post_rst_stall", hif.stall_cnt, 16'd0);
        lit("post_rst_err", 16'(hif.mem_err), 16'd0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
